// File: rtl/sw_reg_unit.sv
// Per-switch register endpoint: buffers 32-bit request frames in a small FIFO,
// executes each as a register write/read and returns a response tagged with op_id.
module sw_reg_unit #(
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WIDTH = 32,
  parameter int W_WIDTH     = 8,
  parameter int NUM_REGS    = 16,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FRAME_WIDTH-1:0] frame_in,
  input  logic                   fifo_wr_en,
  output logic                   fifo_full,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_op_id,
  output logic                   rsp_wr_rd,
  output logic [W_WIDTH-1:0]     rsp_data,
  output logic                   rsp_err,
  output logic [7:0]             ovf_cnt,
  output logic [1:0]             dbg_state_o,
  output logic [CNT_W-1:0]       dbg_count_o
);

  localparam int ENTRY_W = 22;
  localparam int RA_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [7:0]           ovf_q, ovf_d;
  logic [ENTRY_W-1:0]   op_q, op_d;
  logic [W_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [W_WIDTH-1:0]   regs_d [NUM_REGS];

  logic                 rsp_valid_q, rsp_valid_d;
  logic [7:0]           rsp_op_id_q, rsp_op_id_d;
  logic                 rsp_wr_rd_q, rsp_wr_rd_d;
  logic [W_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 full, empty, push, drop, pop;
  logic [4:0]           op_addr;
  logic                 op_wr;
  logic [W_WIDTH-1:0]   op_data;
  logic [7:0]           op_id;
  logic                 addr_ok;
  logic [RA_W-1:0]      reg_idx;
  logic                 unused_frame_hi;

  assign unused_frame_hi = ^frame_in[FRAME_WIDTH-1:ENTRY_W];

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = fifo_wr_en && !full;
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign drop  = fifo_wr_en && full;

  assign op_addr = op_q[21:17];
  assign op_wr   = op_q[16];
  assign op_data = W_WIDTH'(op_q[15:8]);
  assign op_id   = op_q[7:0];
  assign addr_ok = (32'(op_addr) < NUM_REGS);
  assign reg_idx = op_addr[RA_W-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
    if (drop && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
  end

  // Response handshake: rsp_valid rises with all rsp_* fields registered together;
  // while rsp_valid && !rsp_ready every field holds; a cycle with rsp_valid && rsp_ready
  // transfers the response and rsp_valid drops on the following edge.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pop         = 1'b0;
    regs_d      = regs_q;
    rsp_valid_d = rsp_valid_q;
    rsp_op_id_d = rsp_op_id_q;
    rsp_wr_rd_d = rsp_wr_rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          op_d    = mem_q[rd_ptr_q];
          pop     = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_op_id_d = op_id;
        rsp_wr_rd_d = op_wr;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
        if (addr_ok) begin
          rsp_err_d = 1'b0;
          if (op_wr) begin
            regs_d[reg_idx] = op_data;
            rsp_data_d      = op_data;
          end else begin
            rsp_data_d = regs_q[reg_idx];
          end
        end else begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= '0;
      regs_q      <= '{default: '0};
      rsp_valid_q <= 1'b0;
      rsp_op_id_q <= '0;
      rsp_wr_rd_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      regs_q      <= regs_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_id_q <= rsp_op_id_d;
      rsp_wr_rd_q <= rsp_wr_rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= frame_in[ENTRY_W-1:0];
  end

  assign fifo_full   = full;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_op_id   = rsp_op_id_q;
  assign rsp_wr_rd   = rsp_wr_rd_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign ovf_cnt     = ovf_q;
  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;

endmodule

// File: tb/tb_sw_reg_unit.sv
// Directed bench for sw_reg_unit: write/read, backpressure, overflow, out-of-range,
// ordering with FIFO wrap, and reset in the middle of an operation.
module tb_sw_reg_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] frame_in;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_op_id;
  logic        rsp_wr_rd;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [7:0]  ovf_cnt;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_count;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [16:0] exp_q[$];
  logic [7:0]  ref_regs [32];

  sw_reg_unit dut (
    .clk         (clk),
    .rst         (rst),
    .frame_in    (frame_in),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_full   (fifo_full),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_op_id   (rsp_op_id),
    .rsp_wr_rd   (rsp_wr_rd),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .ovf_cnt     (ovf_cnt),
    .dbg_state_o (dbg_state),
    .dbg_count_o (dbg_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] a, input logic wr,
                                     input logic [7:0] d, input logic [7:0] id);
    return {10'h2A5, a, wr, d, id};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] f);
    frame_in   = f;
    fifo_wr_en = 1'b1;
    step();
    fifo_wr_en = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input logic [7:0] id, input logic wr,
                         input logic [7:0] d, input logic err);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(rsp_valid), 32'(1));
    chk({tag, "_id"},    32'(rsp_op_id), 32'(id));
    chk({tag, "_wr"},    32'(rsp_wr_rd), 32'(wr));
    chk({tag, "_data"},  32'(rsp_data),  32'(d));
    chk({tag, "_err"},   32'(rsp_err),   32'(err));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_clr"}, 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    int pushed, got, cyc;
    logic [4:0]  a;
    logic        wr;
    logic [7:0]  d;
    logic [16:0] e;
    logic        stale;

    rst        = 1'b1;
    frame_in   = '0;
    fifo_wr_en = 1'b0;
    rsp_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk("rst_valid", 32'(rsp_valid), 32'(0));
    chk("rst_full",  32'(fifo_full), 32'(0));
    chk("rst_ovf",   32'(ovf_cnt),   32'(0));
    chk("rst_data",  32'(rsp_data),  32'(0));
    chk("rst_id",    32'(rsp_op_id), 32'(0));
    chk("rst_err",   32'(rsp_err),   32'(0));
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // single write, exact latency
    rsp_ready = 1'b1;
    push(mk(5'd3, 1'b1, 8'hA5, 8'h11));
    chk("w1_e0_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("w1_e0_count", 32'(dbg_count), 32'(1));
    step();
    chk("w1_e1_state", 32'(dbg_state), 32'(ST_EXEC));
    chk("w1_e1_valid", 32'(rsp_valid), 32'(0));
    step();
    chk("w1_e2_valid", 32'(rsp_valid), 32'(1));
    chk("w1_e2_id",    32'(rsp_op_id), 32'(8'h11));
    chk("w1_e2_data",  32'(rsp_data),  32'(8'hA5));
    chk("w1_e2_wr",    32'(rsp_wr_rd), 32'(1));
    chk("w1_e2_err",   32'(rsp_err),   32'(0));
    step();
    chk("w1_e3_valid", 32'(rsp_valid), 32'(0));
    chk("w1_e3_state", 32'(dbg_state), 32'(ST_IDLE));
    rsp_ready = 1'b0;
    push(mk(5'd3, 1'b0, 8'h00, 8'h12));
    get_rsp("r3", 8'h12, 1'b0, 8'hA5, 1'b0);

    // backpressure: read response held 5 cycles, write queued behind it
    push(mk(5'd3, 1'b0, 8'h00, 8'h21));
    push(mk(5'd4, 1'b1, 8'h5A, 8'h22));
    step();
    chk("bp_valid", 32'(rsp_valid), 32'(1));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 32'(rsp_valid), 32'(1));
      chk("bp_hold_id",    32'(rsp_op_id), 32'(8'h21));
      chk("bp_hold_data",  32'(rsp_data),  32'(8'hA5));
      chk("bp_hold_state", 32'(dbg_state), 32'(ST_RESP));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_hs_valid", 32'(rsp_valid), 32'(0));
    chk("bp_hs_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    chk("bp_pop_state", 32'(dbg_state), 32'(ST_EXEC));
    get_rsp("bp2", 8'h22, 1'b1, 8'h5A, 1'b0);

    // overflow: 7 back-to-back writes to addr 6..12 with rsp_ready low
    for (int i = 0; i < 7; i++) begin
      frame_in   = mk(5'(6 + i), 1'b1, 8'(8'h40 + i), 8'(8'h30 + i));
      fifo_wr_en = 1'b1;
      step();
      if (i == 3) chk("ovf_full_lo", 32'(fifo_full), 32'(0));
      if (i == 4) chk("ovf_full_hi", 32'(fifo_full), 32'(1));
    end
    fifo_wr_en = 1'b0;
    chk("ovf_cnt",   32'(ovf_cnt),   32'(2));
    chk("ovf_full",  32'(fifo_full), 32'(1));
    chk("ovf_count", 32'(dbg_count), 32'(4));
    chk("ovf_state", 32'(dbg_state), 32'(ST_RESP));
    for (int k = 0; k < 5; k++)
      get_rsp("ovf_rsp", 8'(8'h30 + k), 1'b1, 8'(8'h40 + k), 1'b0);
    step();
    step();
    step();
    chk("ovf_drain_valid", 32'(rsp_valid), 32'(0));
    chk("ovf_drain_count", 32'(dbg_count), 32'(0));
    chk("ovf_drain_full",  32'(fifo_full), 32'(0));
    chk("ovf_cnt_kept",    32'(ovf_cnt),   32'(2));
    push(mk(5'd11, 1'b0, 8'h00, 8'h38));
    get_rsp("ovf_r11", 8'h38, 1'b0, 8'h00, 1'b0);
    push(mk(5'd10, 1'b0, 8'h00, 8'h39));
    get_rsp("ovf_r10", 8'h39, 1'b0, 8'h44, 1'b0);

    // out of range: addr 20 must not alias onto reg 4
    push(mk(5'd20, 1'b1, 8'h3C, 8'h41));
    get_rsp("oor_w", 8'h41, 1'b1, 8'h00, 1'b1);
    push(mk(5'd20, 1'b0, 8'h00, 8'h42));
    get_rsp("oor_r", 8'h42, 1'b0, 8'h00, 1'b1);
    push(mk(5'd31, 1'b0, 8'h00, 8'h44));
    get_rsp("oor_r31", 8'h44, 1'b0, 8'h00, 1'b1);
    push(mk(5'd4, 1'b0, 8'h00, 8'h43));
    get_rsp("oor_r4", 8'h43, 1'b0, 8'h5A, 1'b0);

    // ordering and wrap with random rsp_ready
    for (int i = 0; i < 32; i++) ref_regs[i] = 8'h00;
    ref_regs[3] = 8'hA5;
    ref_regs[4] = 8'h5A;
    for (int i = 0; i < 5; i++) ref_regs[6 + i] = 8'(8'h40 + i);
    pushed = 0;
    got    = 0;
    cyc    = 0;
    while ((pushed < 12 || got < 12) && cyc < 400) begin
      fifo_wr_en = 1'b0;
      if (pushed < 12 && !fifo_full && ($urandom_range(0, 1) == 1)) begin
        wr = (pushed % 2 == 0);
        a  = wr ? 5'(pushed / 2) : 5'((pushed / 2 + 1) % 6);
        d  = wr ? 8'(8'h60 + pushed) : 8'h00;
        frame_in   = mk(a, wr, d, 8'(8'h80 + pushed));
        fifo_wr_en = 1'b1;
        if (wr) ref_regs[a] = d;
        exp_q.push_back({8'(8'h80 + pushed), wr, ref_regs[a]});
        pushed++;
      end
      rsp_ready = ($urandom_range(0, 1) == 1);
      if (rsp_valid && rsp_ready) begin
        chk("ord_q_nonempty", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ord_id",   32'(rsp_op_id), 32'(e[16:9]));
          chk("ord_wr",   32'(rsp_wr_rd), 32'(e[8]));
          chk("ord_data", 32'(rsp_data),  32'(e[7:0]));
          chk("ord_err",  32'(rsp_err),   32'(0));
        end
        got++;
      end
      step();
      cyc++;
    end
    fifo_wr_en = 1'b0;
    rsp_ready  = 1'b0;
    chk("ord_got", 32'(got), 32'(12));

    // reset while in RESP with 3 frames queued
    for (int i = 0; i < 4; i++) begin
      frame_in   = mk(5'd3, 1'b0, 8'h00, 8'(8'h51 + i));
      fifo_wr_en = 1'b1;
      step();
    end
    fifo_wr_en = 1'b0;
    chk("mr_pre_state", 32'(dbg_state), 32'(ST_RESP));
    chk("mr_pre_count", 32'(dbg_count), 32'(3));
    chk("mr_pre_valid", 32'(rsp_valid), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_valid", 32'(rsp_valid), 32'(0));
    chk("mr_full",  32'(fifo_full), 32'(0));
    chk("mr_ovf",   32'(ovf_cnt),   32'(0));
    chk("mr_count", 32'(dbg_count), 32'(0));
    chk("mr_state", 32'(dbg_state), 32'(ST_IDLE));
    rsp_ready = 1'b1;
    stale     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      stale = stale | rsp_valid;
    end
    rsp_ready = 1'b0;
    chk("mr_no_stale", 32'(stale), 32'(0));
    push(mk(5'd3, 1'b0, 8'h00, 8'h61));
    get_rsp("mr_r3", 8'h61, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_reg_unit.md
# sw_reg_unit

Per-switch register endpoint that consumes the 32-bit request frames produced by the upstream bus stage. It buffers frames in a small FIFO, qualified by that instance's one-hot write enable. It then executes each frame as a register write or read against a local register bank and returns a response carrying the original op_id. One instance sits behind each bit of the bus stage's write-enable vector.

## Interface
- FIFO_DEPTH, 4, frame FIFO entries (power of two, >= 2)
- FRAME_WIDTH, 32, request frame width
- W_WIDTH, 8, register data width
- NUM_REGS, 16, implemented registers (1..32)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high (one clock; reset is synchronous and active-high)
- frame_in  in  FRAME_WIDTH  request frame: [21:17] reg addr, [16] wr_rd (1 = write, 0 = read), [15:8] wr data, [7:0] op_id, [31:22] ignored
- fifo_wr_en  in  1  push frame_in this cycle (this instance's bit of the bus write-enable vector)
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- rsp_valid  out  1  response available
- rsp_ready  in  1  downstream accepts response
- rsp_op_id  out  8  op_id of executed frame
- rsp_wr_rd  out  1  wr_rd of executed frame
- rsp_data  out  W_WIDTH  read data, or the written data echoed for writes
- rsp_err  out  1  reg addr >= NUM_REGS
- ovf_cnt  out  8  dropped-frame counter, saturates at 255

## Operation
- Reset: FIFO empty (count 0, pointers 0), register bank all 0, FSM IDLE; all outputs 0.
- Push: if fifo_wr_en && !fifo_full, store frame_in at the write pointer; the pointer wraps modulo FIFO_DEPTH.
- If fifo_wr_en && fifo_full, drop the frame and increment ovf_cnt (saturating). The drop applies even if a pop occurs in the same cycle.
- fifo_full and empty derive from the registered count. Push and pop in the same cycle leave the count unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, latch the head frame into the op register, pop it, and go to EXEC. Otherwise stay in IDLE.
  - EXEC: decode the latched frame.
    - Write with addr < NUM_REGS: reg[addr] <= data, rsp_data <= data.
    - Read with addr < NUM_REGS: rsp_data <= reg[addr].
    - addr >= NUM_REGS: no register change, rsp_data <= 0, rsp_err <= 1.
    - In all cases set rsp_op_id and rsp_wr_rd, set rsp_valid, and go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready, clear rsp_valid and return to IDLE.
- Frames execute strictly in FIFO order. A read following a write to the same address returns the new value.
- The FIFO keeps accepting pushes in every FSM state.
- rst asserted mid-operation: the in-flight op and all queued frames are discarded. Registers and ovf_cnt clear, and rsp_valid is 0 on the cycle after the reset edge.

## Timing
- Frame sampled at edge E0, with FIFO empty and FSM IDLE:
  - E1: popped, state EXEC.
  - E2: executed, state RESP; rsp_valid is high from E2.
- Write-enable edge to rsp_valid: 2 cycles.
- With rsp_ready held high, the response handshake completes at E3, giving a throughput of 1 frame per 3 cycles.
- A back-to-back frame in the FIFO pops at E4: IDLE lasts one cycle before each pop.
- Register write effective from the edge that ends EXEC.
- fifo_full rises the cycle after the push that fills the FIFO and falls the cycle after the next pop.
- No combinational path from rsp_ready or fifo_wr_en to any output.

## Test plan
- Single write:
  - Stimulus: frame addr 3, wr_rd 1, data 0xA5, op_id 0x11, pushed at E0; rsp_ready high.
  - Response: rsp_valid at E2 with op_id 0x11, data 0xA5, wr_rd 1, err 0.
  - Follow-up: a read of addr 3 then returns 0xA5.
- Backpressure:
  - Stimulus: a read response pending; rsp_ready held low 5 cycles.
  - Response: rsp_* stable for all 5 cycles, one handshake only, next frame pops the cycle after return to IDLE.
- Overflow:
  - Stimulus: 7 consecutive pushes with rsp_ready low.
  - Response: 1 frame in execution, FIFO full with 4 more, ovf_cnt = 2. Dropped frames never respond; the 5 accepted frames respond in order.
- Out of range:
  - Stimulus: write addr 20 (NUM_REGS 16) data 0x3C, then a read of addr 20.
  - Response: both carry rsp_err 1 and rsp_data 0; all registers unchanged.
- Ordering and wrap:
  - Stimulus: 12 alternating writes/reads to addresses 0..5 with random rsp_ready.
  - Response: op_ids return in push order, read data matches a reference model, pointers wrap cleanly past FIFO_DEPTH.
- Reset mid-op:
  - Stimulus: assert rst while in RESP with 3 frames queued.
  - Response: next cycle rsp_valid 0, fifo_full 0, ovf_cnt 0, register 3 reads 0, and no stale responses appear afterward.
